mux_bus_responder: RTL and testbench
====================================

// Module: mux_bus_responder
// PURPOSE
//  Memory-side end of the tt_um_6502 multiplexed pin bus. Tracks the 2-cycle bus phase, rebuilds the
//  16-bit address from the time-shared address pins, and decodes read vs write from the CPU's uio output
//  enables. Issues one request per bus cycle to a req/ack memory port and returns read data on the data
//  pins. Sits between the TinyTapeout pins and an external SRAM/ROM model or FPGA memory.
// PARAMETERS
//  TIMEOUT  4   max cycles in WAIT_ACK before the request is abandoned (>=1)
//  OPEN_BUS 8'hFF  read data returned on timeout
// PORTS
//  clk          in   1   clock; same clock as the CPU
//  rst_n        in   1   synchronous active-low reset
//  bus_addr_in  in   8   CPU uo_out: addr[7:0] in LO phase, addr[15:8] in HI phase
//  bus_data_in  in   8   CPU uio_out: write data in HI phase (ignored otherwise)
//  bus_oe_in    in   8   CPU uio_oe: any bit set = CPU write cycle
//  bus_data_out out  8   read data to CPU uio_in
//  bus_data_oe  out  1   responder drives data pins
//  mem_req      out  1   memory request, held until ack or timeout
//  mem_we       out  1   1=write, 0=read; stable while mem_req=1
//  mem_addr     out  16  request address; stable while mem_req=1
//  mem_wdata    out  8   write data; stable while mem_req=1
//  mem_rdata    in   8   read data, valid with mem_ack
//  mem_ack      in   1   1-cycle completion strobe
//  err_overrun  out  1   sticky: bus cycle completed while a request was outstanding
//  err_timeout  out  1   sticky: request abandoned after TIMEOUT cycles
//  txn_count    out  16  completed transactions (ack or timeout), wraps at 16'hFFFF->0
// BEHAVIOUR
//  - All state changes on posedge clk. Reset (rst_n=0 at an edge) clears everything and aborts any
//    request. mem_req=0, bus_data_out=0, outputs 0, phase=LO, state=IDLE. The mem_ack of an aborted
//    request is ignored.
//  - phase toggles every cycle out of reset: LO, HI, LO, ... (first post-reset cycle is LO).
//  - LO cycle: register addr_lo<=bus_addr_in and we_lo<=|bus_oe_in.
//  - HI cycle: register addr_hi<=bus_addr_in and wdata<=bus_data_in. The bus cycle completes at the end
//    of the HI cycle: address={addr_hi,addr_lo}, we=we_lo.
//  - FSM IDLE: at the bus-cycle-complete edge, load mem_addr/mem_we/mem_wdata, set mem_req=1, go to
//    WAIT_ACK, and set the timer to 0.
//  - FSM WAIT_ACK: the timer increments each cycle. mem_ack=1 -> mem_req=0, txn_count+1, go to IDLE. If
//    it was a read, rdata_q<=mem_rdata. The timer reaching TIMEOUT without ack -> mem_req=0,
//    err_timeout=1, txn_count+1, go to IDLE. If it was a read, rdata_q<=OPEN_BUS.
//  - Simultaneous ack and bus-cycle-complete in WAIT_ACK: finish the current transaction and issue the
//    new one in the same edge. mem_req stays 1 and the state stays WAIT_ACK with the new fields. No
//    overrun.
//  - Bus-cycle-complete in WAIT_ACK without ack or timeout: the new transaction is dropped,
//    err_overrun=1, and the outstanding request continues.
//  - Same rule when the timeout edge coincides with bus-cycle-complete: count the timeout, then issue
//    the new request.
//  - bus_data_out=rdata_q (registered). bus_data_oe is combinational, = ~|bus_oe_in, so the responder
//    never drives while the CPU drives.
//  - Sticky errors clear only on reset. Latency: request visible 1 cycle after the HI cycle, and read
//    data on bus_data_out 1 cycle after mem_ack.
// TESTING
//  - Read, ack 1 cycle after req: LO addr_in=34, oe=00, then HI addr_in=12 -> mem_req=1, mem_addr=1234,
//    mem_we=0. Ack with rdata=A9 -> bus_data_out=A9 next cycle, txn_count=1.
//  - Write: LO addr_in=00, oe=FF, then HI addr_in=02, data_in=5C -> mem_addr=0200, mem_we=1,
//    mem_wdata=5C. bus_data_oe=0 during both cycles.
//  - Timeout: read of FFFC with no ack and TIMEOUT=4 -> mem_req falls after 4 cycles, err_timeout=1,
//    bus_data_out=FF. Back-to-back bus cycles meanwhile set err_overrun=1.
//  - Ack on the same edge as the next bus-cycle completion -> mem_req stays 1, mem_addr updates,
//    err_overrun=0.
//  - Reset asserted in WAIT_ACK, then a late mem_ack -> mem_req=0, txn_count=0, rdata_q=0. The first
//    post-reset cycle is LO.
//  - Back-to-back sequential reads 0000..00FF, 1-cycle ack -> 256 requests, txn_count=256, no errors.

Source files
------------

// File: rtl/mux_bus_responder_if.sv
// Pin-bus and memory-port signal bundle for mux_bus_responder.
// The slave view is the responder; the master view is the CPU pins plus the memory model.
interface mux_bus_responder_if;
   logic [7:0]  bus_addr_in;
   logic [7:0]  bus_data_in;
   logic [7:0]  bus_oe_in;
   logic [7:0]  bus_data_out;
   logic        bus_data_oe;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   modport slave (
      input  bus_addr_in, bus_data_in, bus_oe_in, mem_rdata, mem_ack,
      output bus_data_out, bus_data_oe, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output bus_addr_in, bus_data_in, bus_oe_in, mem_rdata, mem_ack,
      input  bus_data_out, bus_data_oe, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mux_bus_responder.sv
// Memory-side end of the tt_um_6502 multiplexed pin bus: rebuilds each 2-cycle bus cycle
// into one req/ack memory transaction and returns read data on the data pins.
module mux_bus_responder #(
   parameter int unsigned TIMEOUT  = 4,
   parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mux_bus_responder_if.slave   bus,
   output logic                 err_overrun,
   output logic                 err_timeout,
   output logic [15:0]          txn_count
);
   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic {PH_LO, PH_HI} phase_t;
   typedef enum logic {ST_IDLE, ST_WAIT_ACK} state_t;

   phase_t        phase_q, phase_d;
   state_t        state_q, state_d;
   logic [7:0]    addr_lo_q, addr_lo_d;
   logic          we_lo_q, we_lo_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [15:0]   addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          ovr_q, ovr_d;
   logic          tmo_q, tmo_d;
   logic [15:0]   txn_q, txn_d;
   logic          cycle_done;
   logic          txn_end;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q   <= PH_LO;
         state_q   <= ST_IDLE;
         addr_lo_q <= '0;
         we_lo_q   <= 1'b0;
         timer_q   <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         ovr_q     <= 1'b0;
         tmo_q     <= 1'b0;
         txn_q     <= '0;
      end else begin
         phase_q   <= phase_d;
         state_q   <= state_d;
         addr_lo_q <= addr_lo_d;
         we_lo_q   <= we_lo_d;
         timer_q   <= timer_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         ovr_q     <= ovr_d;
         tmo_q     <= tmo_d;
         txn_q     <= txn_d;
      end
   end

   always_comb begin
      phase_d    = (phase_q == PH_LO) ? PH_HI : PH_LO;
      state_d    = state_q;
      addr_lo_d  = addr_lo_q;
      we_lo_d    = we_lo_q;
      timer_d    = timer_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      ovr_d      = ovr_q;
      tmo_d      = tmo_q;
      txn_d      = txn_q;
      cycle_done = (phase_q == PH_HI);
      txn_end    = 1'b0;

      if (phase_q == PH_LO) begin
         addr_lo_d = bus.bus_addr_in;
         we_lo_d   = |bus.bus_oe_in;
      end

      case (state_q)
         ST_IDLE: ;
         ST_WAIT_ACK: begin
            timer_d = timer_q + TW'(1);
            // Ack wins over a timeout landing on the same edge.
            if (bus.mem_ack) begin
               txn_end = 1'b1;
               if (!we_q) rdata_d = bus.mem_rdata;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               txn_end = 1'b1;
               tmo_d   = 1'b1;
               if (!we_q) rdata_d = OPEN_BUS;
            end
            if (txn_end) begin
               txn_d   = txn_q + 16'd1;
               req_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (cycle_done) begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The high address byte and write data are taken straight off the pins on the HI edge,
      // so a finishing transaction can hand over to the next one without a bubble.
      if (cycle_done && (state_q == ST_IDLE || txn_end)) begin
         state_d = ST_WAIT_ACK;
         req_d   = 1'b1;
         addr_d  = {bus.bus_addr_in, addr_lo_q};
         we_d    = we_lo_q;
         wdata_d = bus.bus_data_in;
         timer_d = '0;
      end
   end

   assign bus.bus_data_out = rdata_q;
   assign bus.bus_data_oe  = ~|bus.bus_oe_in;
   assign bus.mem_req      = req_q;
   assign bus.mem_we       = we_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign err_overrun      = ovr_q;
   assign err_timeout      = tmo_q;
   assign txn_count        = txn_q;
endmodule

// File: tb/tb_mux_bus_responder.sv
// Directed bench for mux_bus_responder: read, write, timeout/overrun, ack-on-completion,
// reset abort and a 256-read sweep, all with hand-computed expectations.
module tb_mux_bus_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        err_overrun;
   logic        err_timeout;
   logic [15:0] txn_count;
   int          n_chk = 0;
   int          n_bad = 0;

   mux_bus_responder_if bif ();

   mux_bus_responder #(.TIMEOUT(4), .OPEN_BUS(8'hFF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bif),
      .err_overrun (err_overrun),
      .err_timeout (err_timeout),
      .txn_count   (txn_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] addr, input logic [7:0] oe, input logic [7:0] data,
                        input logic ack, input logic [7:0] rdata);
      bif.bus_addr_in = addr;
      bif.bus_oe_in   = oe;
      bif.bus_data_in = data;
      bif.mem_ack     = ack;
      bif.mem_rdata   = rdata;
   endtask

   initial begin
      logic [7:0] b;
      drive(8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_req", bif.mem_req, 0);
      chk("rst_dout", bif.bus_data_out, 0);
      chk("rst_txn", txn_count, 0);
      chk("rst_ovr", err_overrun, 0);
      chk("rst_tmo", err_timeout, 0);
      rst_n = 1'b1;

      // Read 1234, ack one cycle after the request.
      drive(8'h34, 8'h00, 8'h00, 1'b0, 8'h00);
      #1 chk("rd_oe_lo", bif.bus_data_oe, 1);
      step();
      drive(8'h12, 8'h00, 8'h00, 1'b0, 8'h00);
      step();
      chk("rd_req", bif.mem_req, 1);
      chk("rd_addr", bif.mem_addr, 16'h1234);
      chk("rd_we", bif.mem_we, 0);

      // Write 0200 <= 5C; its LO cycle carries the ack for the read.
      drive(8'h00, 8'hFF, 8'h00, 1'b1, 8'hA9);
      #1 chk("wr_oe_lo", bif.bus_data_oe, 0);
      step();
      chk("rd_dout", bif.bus_data_out, 8'hA9);
      chk("rd_txn", txn_count, 1);
      chk("rd_req_drop", bif.mem_req, 0);
      drive(8'h02, 8'hFF, 8'h5C, 1'b0, 8'h00);
      #1 chk("wr_oe_hi", bif.bus_data_oe, 0);
      step();
      chk("wr_req", bif.mem_req, 1);
      chk("wr_addr", bif.mem_addr, 16'h0200);
      chk("wr_we", bif.mem_we, 1);
      chk("wr_wdata", bif.mem_wdata, 8'h5C);

      // Read FFFC never acked; two further bus cycles run meanwhile.
      drive(8'hFC, 8'h00, 8'h00, 1'b1, 8'h11);
      step();
      chk("wr_txn", txn_count, 2);
      chk("wr_dout_keep", bif.bus_data_out, 8'hA9);
      drive(8'hFF, 8'h00, 8'h00, 1'b0, 8'h00);
      step();
      chk("to_req", bif.mem_req, 1);
      chk("to_addr", bif.mem_addr, 16'hFFFC);
      drive(8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      step();
      drive(8'h40, 8'h00, 8'h00, 1'b0, 8'h00);
      step();
      chk("ovr_set", err_overrun, 1);
      chk("ovr_addr_keep", bif.mem_addr, 16'hFFFC);
      chk("ovr_tmo_early", err_timeout, 0);
      drive(8'h11, 8'h00, 8'h00, 1'b0, 8'h00);
      step();
      chk("to_req_c3", bif.mem_req, 1);
      chk("to_not_yet", err_timeout, 0);
      drive(8'h50, 8'h00, 8'h00, 1'b0, 8'h00);
      step();
      chk("to_set", err_timeout, 1);
      chk("to_txn", txn_count, 3);
      chk("to_dout", bif.bus_data_out, 8'hFF);
      chk("to_new_addr", bif.mem_addr, 16'h5011);
      chk("to_new_req", bif.mem_req, 1);

      // Reset while 5011 is outstanding; its ack arrives in the first post-reset cycle.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(8'h78, 8'h00, 8'h00, 1'b1, 8'h77);
      step();
      chk("ra_req", bif.mem_req, 0);
      chk("ra_txn", txn_count, 0);
      chk("ra_dout", bif.bus_data_out, 0);
      chk("ra_ovr", err_overrun, 0);
      chk("ra_tmo", err_timeout, 0);
      drive(8'h56, 8'h00, 8'h00, 1'b0, 8'h00);
      step();
      chk("ra_phase_addr", bif.mem_addr, 16'h5678);
      chk("ra_phase_req", bif.mem_req, 1);

      // Ack on the same edge as the next completion.
      drive(8'h9A, 8'h00, 8'h00, 1'b0, 8'h00);
      step();
      drive(8'hBC, 8'h00, 8'h00, 1'b1, 8'h3C);
      step();
      chk("co_req", bif.mem_req, 1);
      chk("co_addr", bif.mem_addr, 16'hBC9A);
      chk("co_txn", txn_count, 1);
      chk("co_dout", bif.bus_data_out, 8'h3C);
      chk("co_ovr", err_overrun, 0);

      // Sweep reads 0000..00FF with 1-cycle acks.
      drive(8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i <= 256; i++) begin
         b = 8'(i - 1) ^ 8'h5A;
         drive(8'(i), 8'h00, 8'h00, (i > 0), b);
         step();
         if (i > 0) chk("seq_rd", bif.bus_data_out, b);
         if (i == 256) break;
         drive(8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
         step();
         chk("seq_addr", bif.mem_addr, 16'(i));
      end
      chk("seq_txn", txn_count, 256);
      chk("seq_ovr", err_overrun, 0);
      chk("seq_tmo", err_timeout, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
